rom_arbiter: RTL and testbench
==============================

Name: rom_arbiter

Overview:
- Round-robin arbiter that shares one synchronous single-port ROM among p_NUM_REQ requesters.
- The ROM has 1-cycle registered read latency and outputs zero when its read enable is low.
- The arbiter sequences each access as grant, ROM issue, then data capture.
- Sits between the ROM instance and client blocks such as decoders and sequencers.

Parameters:
- p_NUM_REQ, 4, number of requesters (2..16).
- p_ADDRESS_WIDTH, 4, ROM address width.
- p_DATA_WIDTH, 8, ROM data width.

Ports:
- i_CLK  input  1  clock; all state updates on rising edge.
- i_RST  input  1  asynchronous, active-high reset.
- i_REQ  input  p_NUM_REQ  per-requester read request, level.
- i_ADDRESS  input  p_NUM_REQ*p_ADDRESS_WIDTH  flattened addresses; requester k uses bits [k*AW +: AW].
- o_GNT  output  p_NUM_REQ  one-hot, 1-cycle pulse; request accepted, address captured.
- o_VALID  output  p_NUM_REQ  one-hot, 1-cycle pulse; o_READ_DATA holds data for that requester.
- o_READ_DATA  output  p_DATA_WIDTH  shared response data.
- o_ROM_READ_ENABLE  output  1  to ROM read enable.
- o_ROM_ADDRESS  output  p_ADDRESS_WIDTH  to ROM address.
- i_ROM_READ_DATA  input  p_DATA_WIDTH  from ROM read data.

Behaviour:
- All outputs are registered. States: IDLE, ISSUE, CAPTURE (2-bit encoding).
- Reset (async, any time, including mid-access):
  - state=IDLE, o_GNT=0, o_VALID=0, o_READ_DATA=0, o_ROM_READ_ENABLE=0, o_ROM_ADDRESS=0.
  - Round-robin pointer r_LAST=p_NUM_REQ-1, so requester 0 has top priority first.
  - Any in-flight response is discarded; no o_VALID is produced for it.
- IDLE, edge with i_REQ==0: stay IDLE; all pulses low.
- IDLE, edge with i_REQ!=0:
  - Winner w = first set bit searching r_LAST+1, r_LAST+2, ... modulo p_NUM_REQ.
  - Register: o_GNT=onehot(w), o_ROM_READ_ENABLE=1, o_ROM_ADDRESS=i_ADDRESS[w], r_SEL=w, r_LAST=w.
  - Go to ISSUE.
- ISSUE edge: the ROM samples enable/address at this edge. Clear o_GNT and o_ROM_READ_ENABLE; o_ROM_ADDRESS holds. Go to CAPTURE.
- CAPTURE edge:
  - o_READ_DATA=i_ROM_READ_DATA, o_VALID=onehot(r_SEL).
  - Arbitrate exactly as in IDLE at the same edge. If a winner exists, go to ISSUE with grant outputs set; otherwise go to IDLE.
- Cycle timing from the granting edge E0:
  - o_GNT high during E0..E1.
  - ROM enable high during E0..E1.
  - Data captured at E2; o_VALID high during E2..E3.
  - Back-to-back throughput: one read per 2 cycles.
- o_READ_DATA holds its last captured value until the next capture. o_VALID is never asserted without a preceding o_GNT to the same requester.
- Handshake rules:
  - Requester holds i_REQ and i_ADDRESS stable until it sees o_GNT.
  - Address is needed only at the grant edge.
  - A requester wanting another read may keep i_REQ high; it is re-arbitrated at the CAPTURE edge behind any other pending requester.
  - Requests dropped before grant are ignored; no error.
- Fairness: a continuously requesting set of k requesters is each granted once per k grants.
- Single requester held high: granted every 2 cycles.
- Address width: no truncation or extension; addresses pass through unchanged.

Optional Feature:
- Macro ROM_ARBITER_FIXED_PRIORITY_EN.
- Defined: winner is the lowest-indexed set bit of i_REQ. r_LAST is not used and may be removed; starvation of high indices is permitted.
- Undefined (default): round-robin as above.
- All timing, state machine and reset behaviour are identical in both builds.

Test Plan:
- Reset mid-access: assert i_RST during ISSUE -> next cycle state IDLE, all outputs 0; no o_VALID pulse follows for the aborted access.
- Single read: ROM[5]=0xA7; pulse i_REQ=4'b0010, addr1=5 -> o_GNT=4'b0010 one cycle after request edge, o_ROM_READ_ENABLE=1 with address 5 same cycle, o_VALID=4'b0010 with o_READ_DATA=0xA7 two cycles later.
- Simultaneous requests from reset: i_REQ=4'b1111 held, addr k=k, ROM[k]=0x10+k -> grants in order 0,1,2,3,0 at 2-cycle spacing; o_VALID order matches with data 0x10, 0x11, 0x12, 0x13.
- Round-robin wrap: r_LAST=3, i_REQ=4'b1001 -> grant to 0, then 3, then 0.
- Idle gap: no request for 5 cycles after CAPTURE -> o_ROM_READ_ENABLE stays 0, o_READ_DATA holds last value, no pulses.
- With ROM_ARBITER_FIXED_PRIORITY_EN: i_REQ=4'b0101 held -> requester 0 granted every 2 cycles; requester 2 never granted until req0 drops, then granted at the next arbitration edge.

Source files
------------

// File: rtl/rom_arbiter_if.sv
// Requester-side and ROM-side signals around rom_arbiter.
// slave is the arbiter's view; master is the view of the clients and the ROM.
interface rom_arbiter_if #(
  parameter int p_NUM_REQ       = 4,
  parameter int p_ADDRESS_WIDTH = 4,
  parameter int p_DATA_WIDTH    = 8
);
  logic [p_NUM_REQ-1:0]                 i_REQ;
  logic [p_NUM_REQ*p_ADDRESS_WIDTH-1:0] i_ADDRESS;
  logic [p_NUM_REQ-1:0]                 o_GNT;
  logic [p_NUM_REQ-1:0]                 o_VALID;
  logic [p_DATA_WIDTH-1:0]              o_READ_DATA;
  logic                                 o_ROM_READ_ENABLE;
  logic [p_ADDRESS_WIDTH-1:0]           o_ROM_ADDRESS;
  logic [p_DATA_WIDTH-1:0]              i_ROM_READ_DATA;

  modport slave (
    input  i_REQ, i_ADDRESS, i_ROM_READ_DATA,
    output o_GNT, o_VALID, o_READ_DATA, o_ROM_READ_ENABLE, o_ROM_ADDRESS
  );

  modport master (
    output i_REQ, i_ADDRESS, i_ROM_READ_DATA,
    input  o_GNT, o_VALID, o_READ_DATA, o_ROM_READ_ENABLE, o_ROM_ADDRESS
  );
endinterface

// File: rtl/rom_arbiter.sv
// Round-robin arbiter sharing one 1-cycle-latency ROM among p_NUM_REQ requesters.
// Define ROM_ARBITER_FIXED_PRIORITY_EN for lowest-index-wins arbitration instead.
module rom_arbiter #(
  parameter int p_NUM_REQ       = 4,
  parameter int p_ADDRESS_WIDTH = 4,
  parameter int p_DATA_WIDTH    = 8
) (
  input  logic          i_CLK,
  input  logic          i_RST,
  rom_arbiter_if.slave  bus
);
  localparam int IDX_W = (p_NUM_REQ > 1) ? $clog2(p_NUM_REQ) : 1;

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] CAPTURE = 2'd2;

  logic [1:0]                 state_q, state_d;
  logic [p_NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [p_NUM_REQ-1:0]       valid_q, valid_d;
  logic [p_DATA_WIDTH-1:0]    read_data_q, read_data_d;
  logic                       rom_en_q, rom_en_d;
  logic [p_ADDRESS_WIDTH-1:0] rom_addr_q, rom_addr_d;
  logic [IDX_W-1:0]           sel_q, sel_d;
`ifndef ROM_ARBITER_FIXED_PRIORITY_EN
  logic [IDX_W-1:0]           last_q, last_d;
  logic [IDX_W-1:0]           cand;
`endif

  logic             win_found;
  logic [IDX_W-1:0] win_idx;

  // Winner selection; only consulted on IDLE and CAPTURE edges.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
`ifdef ROM_ARBITER_FIXED_PRIORITY_EN
    for (int i = p_NUM_REQ - 1; i >= 0; i--) begin
      if (bus.i_REQ[i]) begin
        win_found = 1'b1;
        win_idx   = IDX_W'(i);
      end
    end
`else
    cand = '0;
    for (int i = 1; i <= p_NUM_REQ; i++) begin
      cand = IDX_W'((int'(last_q) + i) % p_NUM_REQ);
      if (!win_found && bus.i_REQ[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
`endif
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latches).
    state_d     = state_q;
    gnt_d       = '0;
    valid_d     = '0;
    read_data_d = read_data_q;
    rom_en_d    = 1'b0;
    rom_addr_d  = rom_addr_q;
    sel_d       = sel_q;
`ifndef ROM_ARBITER_FIXED_PRIORITY_EN
    last_d      = last_q;
`endif

    if (state_q == CAPTURE) begin
      read_data_d    = bus.i_ROM_READ_DATA;
      valid_d[sel_q] = 1'b1;
      state_d        = IDLE;
    end

    if (state_q == ISSUE) begin
      state_d = CAPTURE;
    end else if (win_found) begin
      // IDLE or CAPTURE: a new access may start at this edge.
      gnt_d[win_idx] = 1'b1;
      rom_en_d       = 1'b1;
      rom_addr_d     = bus.i_ADDRESS[win_idx*p_ADDRESS_WIDTH +: p_ADDRESS_WIDTH];
      sel_d          = win_idx;
`ifndef ROM_ARBITER_FIXED_PRIORITY_EN
      last_d         = win_idx;
`endif
      state_d        = ISSUE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_CLK or posedge i_RST) begin
    if (i_RST) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      valid_q     <= '0;
      read_data_q <= '0;
      rom_en_q    <= 1'b0;
      rom_addr_q  <= '0;
      sel_q       <= '0;
`ifndef ROM_ARBITER_FIXED_PRIORITY_EN
      last_q      <= IDX_W'(p_NUM_REQ - 1);
`endif
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      valid_q     <= valid_d;
      read_data_q <= read_data_d;
      rom_en_q    <= rom_en_d;
      rom_addr_q  <= rom_addr_d;
      sel_q       <= sel_d;
`ifndef ROM_ARBITER_FIXED_PRIORITY_EN
      last_q      <= last_d;
`endif
    end
  end

  assign bus.o_GNT             = gnt_q;
  assign bus.o_VALID           = valid_q;
  assign bus.o_READ_DATA       = read_data_q;
  assign bus.o_ROM_READ_ENABLE = rom_en_q;
  assign bus.o_ROM_ADDRESS     = rom_addr_q;
endmodule

// File: tb/tb_rom_arbiter.sv
// Self-checking bench for rom_arbiter: a ROM model, a transaction-history reference
// model and scenario tasks; honours ROM_ARBITER_FIXED_PRIORITY_EN like the design.
module tb_rom_arbiter;
  localparam int N   = 4;
  localparam int AW  = 4;
  localparam int DW  = 8;
  localparam int AWT = N * AW;
  localparam int VW  = 2 * N + 1 + AW + DW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  rom_arbiter_if #(.p_NUM_REQ(N), .p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) bus ();

  rom_arbiter #(.p_NUM_REQ(N), .p_ADDRESS_WIDTH(AW), .p_DATA_WIDTH(DW)) dut (
    .i_CLK (clk),
    .i_RST (rst),
    .bus   (bus)
  );

  // Synchronous ROM: registered read, zero when not enabled.
  logic [DW-1:0] rom_mem [2**AW];
  always_ff @(posedge clk)
    bus.i_ROM_READ_DATA <= bus.o_ROM_READ_ENABLE ? rom_mem[bus.o_ROM_ADDRESS] : '0;

  int checks = 0;
  int errors = 0;

  // Reference model: remembers the grants of the last two edges.
  int            m_last;
  bit            p1_v, p2_v;
  int            p1_idx, p2_idx;
  logic [AW-1:0] p1_addr, p2_addr;
  logic [N-1:0]  exp_gnt, exp_valid;
  logic          exp_en;
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  task automatic model_reset();
    m_last = N - 1;
    p1_v = 1'b0; p2_v = 1'b0; p1_idx = 0; p2_idx = 0; p1_addr = '0; p2_addr = '0;
    exp_gnt = '0; exp_valid = '0; exp_en = 1'b0; exp_addr = '0; exp_data = '0;
  endtask

  function automatic int pick(logic [N-1:0] req);
    int order[$];
`ifdef ROM_ARBITER_FIXED_PRIORITY_EN
    for (int i = 0; i < N; i++) order.push_back(i);
`else
    for (int i = m_last + 1; i < N; i++) order.push_back(i);
    for (int i = 0; i <= m_last; i++) order.push_back(i);
`endif
    foreach (order[j]) if (req[order[j]]) return order[j];
    return -1;
  endfunction

  // A new grant is possible at an edge unless the previous edge granted;
  // data for a grant appears two edges later.
  task automatic model_step();
    int w;
    logic [N-1:0] req;
    req = bus.i_REQ;
    exp_valid = '0;
    if (p2_v) begin
      exp_valid[p2_idx] = 1'b1;
      exp_data = rom_mem[p2_addr];
    end
    exp_gnt = '0;
    exp_en  = 1'b0;
    w = -1;
    if (!p1_v && req != '0) begin
      w = pick(req);
      exp_gnt[w] = 1'b1;
      exp_en     = 1'b1;
      exp_addr   = bus.i_ADDRESS[w*AW +: AW];
      m_last     = w;
    end
    p2_v = p1_v; p2_idx = p1_idx; p2_addr = p1_addr;
    p1_v = (w >= 0); p1_idx = w; p1_addr = exp_addr;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  function automatic logic [VW-1:0] exp_vec();
    return {exp_gnt, exp_valid, exp_en, exp_addr, exp_data};
  endfunction

  function automatic logic [VW-1:0] act_vec();
    return {bus.o_GNT, bus.o_VALID, bus.o_ROM_READ_ENABLE, bus.o_ROM_ADDRESS, bus.o_READ_DATA};
  endfunction

  task automatic apply_reset();
    bus.i_REQ = '0;
    rst = 1'b1;
    #2;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    bus.i_REQ = '0;
    bus.i_ADDRESS = '0;
    rst = 1'b1;
    #3;
    checks++;
    if (act_vec() !== '0) begin
      errors++;
      $display("FAIL reset_outputs got %h expected %h", act_vec(), {VW{1'b0}});
    end
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL reset_idle cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_read();
    apply_reset();
    rom_mem[5] = 8'hA7;
    bus.i_ADDRESS = '0;
    bus.i_ADDRESS[1*AW +: AW] = 4'd5;
    bus.i_REQ = 4'b0010;
    for (int c = 0; c < 4; c++) begin
      tick();
      if (c == 0) bus.i_REQ = '0;
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL single_read cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
      if (c == 0) begin
        checks++;
        if ({bus.o_GNT, bus.o_ROM_READ_ENABLE, bus.o_ROM_ADDRESS} !== {4'b0010, 1'b1, 4'd5}) begin
          errors++;
          $display("FAIL single_read_grant got gnt %b en %b addr %0d expected 0010 1 5",
                   bus.o_GNT, bus.o_ROM_READ_ENABLE, bus.o_ROM_ADDRESS);
        end
      end
      if (c == 2) begin
        checks++;
        if ({bus.o_VALID, bus.o_READ_DATA} !== {4'b0010, 8'hA7}) begin
          errors++;
          $display("FAIL single_read_data got valid %b data %h expected 0010 a7",
                   bus.o_VALID, bus.o_READ_DATA);
        end
      end
    end
  endtask

  task automatic test_all_four();
    int gq[$];
    logic [DW-1:0] dq[$];
    int exp_order[5] = '{0, 1, 2, 3, 0};
    logic [DW-1:0] exp_rd[4] = '{8'h10, 8'h11, 8'h12, 8'h13};
    apply_reset();
    for (int k = 0; k < N; k++) begin
      rom_mem[k] = DW'(8'h10 + k);
      bus.i_ADDRESS[k*AW +: AW] = AW'(k);
    end
    bus.i_REQ = 4'b1111;
    for (int c = 0; c < 13; c++) begin
      if (c == 10) bus.i_REQ = '0;
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL all_four cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
      if (c < 10 && bus.o_GNT != '0) gq.push_back($clog2(bus.o_GNT));
      if (c < 10 && bus.o_VALID != '0) dq.push_back(bus.o_READ_DATA);
    end
`ifndef ROM_ARBITER_FIXED_PRIORITY_EN
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ((i < gq.size() ? gq[i] : -1) !== exp_order[i]) begin
        errors++;
        $display("FAIL all_four_order grant %0d got %0d expected %0d", i,
                 (i < gq.size() ? gq[i] : -1), exp_order[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((i < dq.size() ? dq[i] : 8'hxx) !== exp_rd[i]) begin
        errors++;
        $display("FAIL all_four_data read %0d got %h expected %h", i,
                 (i < dq.size() ? dq[i] : 8'hxx), exp_rd[i]);
      end
    end
`endif
  endtask

  task automatic test_wrap();
    int gq[$];
    int exp_order[3] = '{0, 3, 0};
    apply_reset();
    bus.i_ADDRESS = AWT'($urandom);
    bus.i_REQ = 4'b1001;
    for (int c = 0; c < 9; c++) begin
      if (c == 6) bus.i_REQ = '0;
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL wrap cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
      if (bus.o_GNT != '0) gq.push_back($clog2(bus.o_GNT));
    end
`ifndef ROM_ARBITER_FIXED_PRIORITY_EN
    for (int i = 0; i < 3; i++) begin
      checks++;
      if ((i < gq.size() ? gq[i] : -1) !== exp_order[i]) begin
        errors++;
        $display("FAIL wrap_order grant %0d got %0d expected %0d", i,
                 (i < gq.size() ? gq[i] : -1), exp_order[i]);
      end
    end
`endif
  endtask

  task automatic test_idle_gap();
    bus.i_REQ = '0;
    for (int c = 0; c < 5; c++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec() || bus.o_ROM_READ_ENABLE !== 1'b0 || bus.o_VALID !== '0) begin
        errors++;
        $display("FAIL idle_gap cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int ngnt = 0;
    apply_reset();
    bus.i_ADDRESS = AWT'($urandom);
    bus.i_REQ = 4'b0001;
    for (int c = 0; c < 8; c++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL back_to_back cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
      if (bus.o_GNT == 4'b0001) ngnt++;
    end
    checks++;
    if (ngnt !== 4) begin
      errors++;
      $display("FAIL back_to_back_count got %0d expected 4", ngnt);
    end
    bus.i_REQ = '0;
  endtask

  task automatic test_mid_reset();
    apply_reset();
    bus.i_ADDRESS = AWT'($urandom);
    bus.i_REQ = 4'b0100;
    tick();
    bus.i_REQ = '0;
    checks++;
    if (act_vec() !== exp_vec()) begin
      errors++;
      $display("FAIL mid_reset_grant got %h expected %h", act_vec(), exp_vec());
    end
    rst = 1'b1;
    #1;
    checks++;
    if (act_vec() !== '0) begin
      errors++;
      $display("FAIL mid_reset_clear got %h expected %h", act_vec(), {VW{1'b0}});
    end
    #1;
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 4; c++) begin
      tick();
      checks++;
      if (act_vec() !== exp_vec() || bus.o_VALID !== '0) begin
        errors++;
        $display("FAIL mid_reset_after cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
    end
  endtask

`ifdef ROM_ARBITER_FIXED_PRIORITY_EN
  task automatic test_fixed_priority();
    int gq[$];
    int exp_order[4] = '{0, 0, 0, 2};
    apply_reset();
    bus.i_ADDRESS = AWT'($urandom);
    bus.i_REQ = 4'b0101;
    for (int c = 0; c < 10; c++) begin
      if (c == 6) bus.i_REQ = 4'b0100;
      if (c == 7) bus.i_REQ = '0;
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL fixed_priority cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
      if (bus.o_GNT != '0) gq.push_back($clog2(bus.o_GNT));
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ((i < gq.size() ? gq[i] : -1) !== exp_order[i]) begin
        errors++;
        $display("FAIL fixed_priority_order grant %0d got %0d expected %0d", i,
                 (i < gq.size() ? gq[i] : -1), exp_order[i]);
      end
    end
  endtask
`endif

  task automatic test_random();
    apply_reset();
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = DW'($urandom);
    for (int c = 0; c < 400; c++) begin
      bus.i_REQ     = ($urandom_range(0, 3) == 0) ? '0 : N'($urandom);
      bus.i_ADDRESS = AWT'($urandom);
      tick();
      checks++;
      if (act_vec() !== exp_vec()) begin
        errors++;
        $display("FAIL random cyc %0d got %h expected %h", c, act_vec(), exp_vec());
      end
    end
    bus.i_REQ = '0;
  endtask

  initial begin
    for (int i = 0; i < 2**AW; i++) rom_mem[i] = DW'($urandom);
    test_reset();
    test_single_read();
    test_all_four();
    test_wrap();
    test_idle_gap();
    test_back_to_back();
    test_mid_reset();
`ifdef ROM_ARBITER_FIXED_PRIORITY_EN
    test_fixed_priority();
`endif
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
